// File: rtl/fifo_status_ctrl.sv
// fifo_status_ctrl
// Control and status stage of a synchronous extra-bit FIFO. This block owns the
// write pointer. It qualifies raw requests into enables and derives full/empty
// and fill level from the write pointer and the returned read pointer. It also
// keeps registered almost-full/almost-empty flags and sticky overflow/underflow
// errors.
module fifo_status_ctrl #(
    parameter int ADDRESS_SIZE = 3,
    parameter int AF_LEVEL     = 6,
    parameter int AE_LEVEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic                  clr_err,
    input  logic [ADDRESS_SIZE:0] r_ptr,
    output logic [ADDRESS_SIZE:0] w_ptr,
    output logic                  cw_en,
    output logic                  cr_en,
    output logic                  full,
    output logic                  empty,
    output logic [ADDRESS_SIZE:0] fill_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDRESS_SIZE + 1;

    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full_s;
    logic          empty_s;
    logic          cw_en_s;
    logic          cr_en_s;
    logic [PW-1:0] fill_s;
    logic [PW-1:0] next_occ_s;

    // Occupancy after this cycle's qualified transfers. It cannot leave
    // 0..depth because the enables are already gated by full/empty.
    function automatic logic [PW-1:0] next_occupancy(
        input logic [PW-1:0] occ,
        input logic          wen,
        input logic          ren
    );
        next_occupancy = occ + {{(PW-1){1'b0}}, wen} - {{(PW-1){1'b0}}, ren};
    endfunction

    // Pointer comparison, fill level and request qualification.
    always_comb begin
        empty_s    = (w_ptr_q == r_ptr);
        full_s     = (w_ptr_q[PW-1] != r_ptr[PW-1]) &&
                     (w_ptr_q[PW-2:0] == r_ptr[PW-2:0]);
        fill_s     = w_ptr_q - r_ptr;
        cw_en_s    = wr_req & ~full_s;
        cr_en_s    = rd_req & ~empty_s;
        next_occ_s = next_occupancy(fill_s, cw_en_s, cr_en_s);
    end

    // Next-state values for the pointer, the almost flags and the sticky errors.
    // For the error flags, a new error event wins over a clear in the same cycle.
    always_comb begin
        w_ptr_d        = w_ptr_q;
        almost_full_d  = (next_occ_s >= AF_THRESH);
        almost_empty_d = (next_occ_s <= AE_THRESH);
        overflow_d     = (wr_req & full_s)  | (overflow_q  & ~clr_err);
        underflow_d    = (rd_req & empty_s) | (underflow_q & ~clr_err);
        if (cw_en_s) begin
            w_ptr_d = w_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            w_ptr_d = w_ptr_q;
        end
    end

    // State registers with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr_q        <= {PW{1'b0}};
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            w_ptr_q        <= w_ptr_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign w_ptr        = w_ptr_q;
    assign cw_en        = cw_en_s;
    assign cr_en        = cr_en_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign fill_level   = fill_s;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Testbench for fifo_status_ctrl. The bench acts as the read address counter and
// drives r_ptr. An occupancy-count reference model predicts every output.
// Directed sequences are followed by randomized traffic.
module tb_fifo_status_ctrl;

    localparam int AS    = 3;
    localparam int DEPTH = 1 << AS;
    localparam int PMOD  = 1 << (AS + 1);

    logic          clk;
    logic          rst_n;
    logic          wr_req;
    logic          rd_req;
    logic          clr_err;
    logic [AS:0]   r_ptr;
    logic [AS:0]   w_ptr;
    logic          cw_en;
    logic          cr_en;
    logic          full;
    logic          empty;
    logic [AS:0]   fill_level;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int n_vec;
    int n_err;

    // Reference model: the number of stored words, the number of writes and
    // reads modulo the pointer range, and the sticky error bits.
    int m_occ;
    int m_wcnt;
    int m_rcnt;
    bit m_ovf;
    bit m_udf;

    fifo_status_ctrl #(.ADDRESS_SIZE(AS), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .clr_err      (clr_err),
        .r_ptr        (r_ptr),
        .w_ptr        (w_ptr),
        .cw_en        (cw_en),
        .cr_en        (cr_en),
        .full         (full),
        .empty        (empty),
        .fill_level   (fill_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ  = 0;
        m_wcnt = 0;
        m_rcnt = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // One clock cycle: apply inputs and check every output against the model.
    // Then advance the model and the emulated read counter past the edge.
    task automatic step(input bit w, input bit rd, input bit c, input bit rn);
        bit we, re;
        @(negedge clk);
        wr_req  = w;
        rd_req  = rd;
        clr_err = c;
        rst_n   = rn;
        #1;
        we = w  && (m_occ < DEPTH);
        re = rd && (m_occ > 0);
        check_val("w_ptr",        32'(w_ptr),      32'(m_wcnt));
        check_val("fill_level",   32'(fill_level), 32'(m_occ));
        check_val("full",         32'(full),       32'(m_occ == DEPTH));
        check_val("empty",        32'(empty),      32'(m_occ == 0));
        check_val("cw_en",        32'(cw_en),      32'(we));
        check_val("cr_en",        32'(cr_en),      32'(re));
        check_val("almost_full",  32'(almost_full),  32'(m_occ >= 6));
        check_val("almost_empty", 32'(almost_empty), 32'(m_occ <= 2));
        check_val("overflow",     32'(overflow),   32'(m_ovf));
        check_val("underflow",    32'(underflow),  32'(m_udf));
        @(posedge clk);
        #1;
        if (!rn) begin
            model_reset();
        end else begin
            m_ovf  = (w && (m_occ == DEPTH)) || (m_ovf && !c);
            m_udf  = (rd && (m_occ == 0))    || (m_udf && !c);
            m_occ  = m_occ + int'(we) - int'(re);
            m_wcnt = (m_wcnt + int'(we)) % PMOD;
            m_rcnt = (m_rcnt + int'(re)) % PMOD;
        end
        r_ptr = (AS + 1)'(m_rcnt);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
        r_ptr   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Fill from empty to full.
        repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Write while full sets overflow. A clear in the same cycle as a set
        // must lose to the set; a clear on its own must take effect.
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous requests while full: only the read proceeds.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Drain to empty, then read while empty, then write and read while empty.
        repeat (7) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Reach four words, then stream with both requests so w_ptr wraps.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation at five words with both requests active.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with phases biased towards filling and towards draining.
        for (int i = 0; i < 3000; i++) begin
            int  phase;
            bit  w, rd, c, rn;
            phase = (i / 100) % 3;
            w  = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            rd = (phase == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 127) != 0);
            step(w, rd, c, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_status_ctrl.md
Name: fifo_status_ctrl

Overview:
Control and status stage of the synchronous extra-bit FIFO. It sits directly upstream of the read address counter and drives that counter's read enable.
- Owns the write pointer counter.
- Qualifies raw write/read requests into the write and read enables.
- Derives full/empty from the extra-bit pointer comparison.
- Produces fill level, registered almost-full/almost-empty flags and sticky overflow/underflow errors.

Parameters:
ADDRESS_SIZE, 3, memory address width; memory depth = 2**ADDRESS_SIZE (8); pointers are ADDRESS_SIZE+1 bits
AF_LEVEL, 6, almost_full asserts when occupancy >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when occupancy <= AE_LEVEL

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous reset, active-low
wr_req  input  1  producer write request
rd_req  input  1  consumer read request
clr_err  input  1  clears sticky error flags
r_ptr  input  ADDRESS_SIZE+1  read pointer returned by the read address counter
w_ptr  output  ADDRESS_SIZE+1  write pointer, memory write address = low ADDRESS_SIZE bits
cw_en  output  1  qualified write enable (to memory and internal write counter)
cr_en  output  1  qualified read enable (to read address counter)
full  output  1  FIFO full (combinational)
empty  output  1  FIFO empty (combinational)
fill_level  output  ADDRESS_SIZE+1  occupancy 0..2**ADDRESS_SIZE (combinational)
almost_full  output  1  registered
almost_empty  output  1  registered
overflow  output  1  sticky: write requested while full
underflow  output  1  sticky: read requested while empty

Behaviour:
- Reset (rst_n low at clk edge) values:
  - w_ptr=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - The read counter resets on the same rst_n, so empty=1, full=0, fill_level=0 after reset.
  - Reset has priority over every other input.
- Reset mid-operation discards all contents: pointers return to 0 regardless of in-flight requests.
- Pointer comparison:
  - empty = (w_ptr == r_ptr).
  - full = (MSBs differ) and (low ADDRESS_SIZE bits equal).
- fill_level = w_ptr - r_ptr, modulo 2**(ADDRESS_SIZE+1).
- Enables (combinational):
  - cw_en = wr_req & ~full.
  - cr_en = rd_req & ~empty.
- Write pointer:
  - Increments by 1 on each clk with cw_en=1.
  - Wraps naturally through all 2**(ADDRESS_SIZE+1) values; no clamp at depth.
- Latency: a write is visible in empty/fill_level on the cycle after cw_en. The same one-cycle latency applies to reads via r_ptr.
- Simultaneous wr_req & rd_req:
  - Non-empty, non-full: both enabled; fill_level unchanged.
  - Full: only the read proceeds; the write is dropped and overflow is set.
  - Empty: only the write proceeds; the read is dropped and underflow is set.
- Almost flags:
  - Registered from next occupancy: next = fill_level + cw_en - cr_en.
  - almost_full <= (next >= AF_LEVEL); almost_empty <= (next <= AE_LEVEL).
  - Both flags are therefore coherent with fill_level on every cycle, with no lag.
- Error flags:
  - overflow sets on any cycle with wr_req & full; underflow sets on any cycle with rd_req & empty.
  - Both hold until clr_err=1 or reset.
  - If a set condition and clr_err occur in the same cycle, set wins.
- No state machine beyond the counter and flag registers. All arithmetic is unsigned, ADDRESS_SIZE+1 bits wide.

Test Plan:
1. Reset → w_ptr=0, empty=1, full=0, fill_level=0, almost_empty=1, almost_full=0, overflow=underflow=0.
2. 8 consecutive wr_req cycles from empty → w_ptr 0..8, fill_level 8, full=1 after 8th write, almost_full=1 once fill_level reaches 6, almost_empty=0 once fill_level reaches 3.
3. Full + wr_req alone → cw_en=0, w_ptr stays 8, overflow=1 and stays 1. Next cycle clr_err=1 → overflow=0.
4. Empty + rd_req alone → cr_en=0, underflow=1. Empty + wr_req & rd_req → cw_en=1, cr_en=0, fill_level=1 next cycle.
5. fill_level=4 with wr_req & rd_req held 20 cycles → fill_level stays 4. w_ptr wraps 15→0 with its extra bit toggling. full and empty stay 0 throughout.
6. rst_n low for one cycle at fill_level=5 with both requests active → next cycle w_ptr=0, empty=1, almost_empty=1, error flags cleared.
